// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Issue controller for the decode stage. A per-register countdown scoreboard
// tracks in-flight register writes. Each cycle the controller decides whether
// the instruction in decode may issue into the decode/execute register, or
// must be held while a bubble is loaded into decode/execute.
//
// Parameters
//   DEPTH       cycles from issue until the register-file write completes
//               (EXE, MEM, WB); legal range 2..7
//   GPR_ADDR_W  register address width
//
// Ports
//   clk_i        in   clock, all state updates on the rising edge
//   rst_i        in   synchronous, active-high reset
//   id_valid_i   in   decode holds a real instruction
//   rs1_addr_i   in   source 1 register address
//   rs2_addr_i   in   source 2 register address
//   rs1_used_i   in   instruction reads rs1
//   rs2_used_i   in   instruction reads rs2
//   rd_addr_i    in   destination register address
//   rd_we_i      in   instruction writes rd
//   is_load_i    in   instruction is a load
//   flush_i      in   kill the decode instruction
//   stall_o      out  hold PC and the fetch/decode register
//   issue_o      out  decode instruction advances into decode/execute
//   bubble_o     out  load a NOP into decode/execute (always !issue_o)
//   stall_cnt_o  out  saturating count of stalled cycles
//
// Configuration
//   HAZARD_FWD_EN  defined: execute forwards from EXE/MEM/WB, so only a load
//                  that is currently in EXE blocks a consumer.
//                  undefined: any pending write blocks a consumer.
// ============================================================================
module hazard_ctrl #(
    parameter int DEPTH      = 3,
    parameter int GPR_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [GPR_ADDR_W-1:0] rs1_addr_i,
    input  logic [GPR_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [GPR_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_we_i,
    input  logic                  is_load_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  issue_o,
    output logic                  bubble_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int         NREG    = 1 << GPR_ADDR_W;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    // ------------------------------------------------------------------------
    // Scoreboard state. Entry 0 is reset to zero and never written, so x0
    // always reads as "no write pending".
    // ------------------------------------------------------------------------
    logic [2:0] cnt_q [NREG];
`ifdef HAZARD_FWD_EN
    logic       ld_q  [NREG];
`else
    // Load information only matters when forwarding is present.
    logic       unused_is_load;
    assign unused_is_load = is_load_i;
`endif

    logic            pend_rs1;
    logic            pend_rs2;
    logic            hazard_rs1;
    logic            hazard_rs2;
    logic            hazard;
    logic            wr_en;
    logic [NREG-1:0] wr_sel;
    logic [31:0]     stall_cnt_q;

    // ------------------------------------------------------------------------
    // Pending-write lookup for both source operands.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
`ifdef HAZARD_FWD_EN
        // With forwarding, only a load that issued on the last edge (its
        // count still at DEPTH, i.e. sitting in EXE) cannot supply data yet.
        pend_rs1 = ld_q[rs1_addr_i] && (cnt_q[rs1_addr_i] == DEPTH_C);
        pend_rs2 = ld_q[rs2_addr_i] && (cnt_q[rs2_addr_i] == DEPTH_C);
`else
        // Without forwarding the consumer waits until the write has retired;
        // cnt==1 is WB and the register file is only updated at its end.
        pend_rs1 = (cnt_q[rs1_addr_i] != 3'd0);
        pend_rs2 = (cnt_q[rs2_addr_i] != 3'd0);
`endif
    end

    // ------------------------------------------------------------------------
    // Issue decision. The scoreboard only reflects older instructions, so a
    // source that equals its own rd never creates a self-hazard.
    // ------------------------------------------------------------------------
    always_comb begin
        hazard_rs1 = rs1_used_i && (rs1_addr_i != '0) && pend_rs1;
        hazard_rs2 = rs2_used_i && (rs2_addr_i != '0) && pend_rs2;
        // The scoreboard may still hold stale counts during the first reset
        // cycle; reset masks them so no stall is ever raised in reset.
        hazard     = id_valid_i && !rst_i && (hazard_rs1 || hazard_rs2);
        // A flush discards the decode instruction instead of holding it.
        stall_o    = hazard && !flush_i;
        issue_o    = id_valid_i && !hazard && !flush_i;
        bubble_o   = !issue_o;
    end

    // ------------------------------------------------------------------------
    // Scoreboard write select: one-hot on rd for an issuing writer. x0 writes
    // are dropped here, so entry 0 never leaves zero.
    // ------------------------------------------------------------------------
    always_comb begin
        wr_en  = issue_o && rd_we_i && (rd_addr_i != '0);
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[rd_addr_i] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Countdown update. Counts decrement every edge regardless of stalls,
    // because the pipe behind decode never stalls. A new writer reloads DEPTH
    // over the decrement, so the youngest writer of a register wins. Flushes
    // leave the scoreboard alone: older instructions still write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: this array is a bank of flops, not a RAM; leftover counts
            // would fake hazards after reset, so every entry is cleared.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_sel[r]) begin
                    // NOTE: sequential state uses non-blocking assignments so
                    // every flop samples the pre-edge values of its inputs.
                    cnt_q[r] <= DEPTH_C;
                end else if (cnt_q[r] != 3'd0) begin
                    cnt_q[r] <= cnt_q[r] - 3'd1;
                end
            end
        end
    end

`ifdef HAZARD_FWD_EN
    // Load flag of the youngest writer of each register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                ld_q[r] <= 1'b0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_sel[r]) begin
                    ld_q[r] <= is_load_i;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Saturating stall-cycle counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for hazard_ctrl (DEPTH=3, 5-bit register addresses).
// The reference model records, per register, the edge number at which its
// youngest writer issued; a write is pending while fewer than DEPTH edges
// have passed since then (with HAZARD_FWD_EN: only a load on the edge it
// issued). Inputs change 1 time unit after the rising edge and outputs are
// sampled on the falling edge.
// ============================================================================
module tb_hazard_ctrl;

    localparam int DEPTH = 3;
    localparam int AW    = 5;

`ifdef HAZARD_FWD_EN
    localparam int EXP_LOAD_USE = 1;
    localparam int EXP_ALU_USE  = 0;
`else
    localparam int EXP_LOAD_USE = DEPTH;
    localparam int EXP_ALU_USE  = DEPTH;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic          rs1_used_i;
    logic          rs2_used_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_we_i;
    logic          is_load_i;
    logic          flush_i;
    logic          stall_o;
    logic          issue_o;
    logic          bubble_o;
    logic [31:0]   stall_cnt_o;

    hazard_ctrl #(
        .DEPTH      (DEPTH),
        .GPR_ADDR_W (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .id_valid_i  (id_valid_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_used_i  (rs1_used_i),
        .rs2_used_i  (rs2_used_i),
        .rd_addr_i   (rd_addr_i),
        .rd_we_i     (rd_we_i),
        .is_load_i   (is_load_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .issue_o     (issue_o),
        .bubble_o    (bubble_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------------------------------------------------------- model
    int          m_now = 0;
    bit          m_busy    [32];
    int          m_issue_t [32];
`ifdef HAZARD_FWD_EN
    bit          m_ld      [32];
`endif
    logic [31:0] m_stall_cnt = '0;

    // Per-cycle expected and observed values, filled by tick().
    bit          exp_stall, exp_issue, exp_bubble;
    logic [31:0] exp_cnt;
    logic        obs_stall, obs_issue, obs_bubble;
    logic [31:0] obs_cnt;

    function automatic bit m_pending(input logic [AW-1:0] r);
        int age;
        if (r == 0 || !m_busy[r]) return 1'b0;
        age = m_now - m_issue_t[r];
`ifdef HAZARD_FWD_EN
        return m_ld[r] && (age == 0);
`else
        return age < DEPTH;
`endif
    endfunction

    // One clock cycle: compute expectations, sample DUT, advance the model.
    task automatic tick();
        bit hz;
        @(negedge clk);
        hz = !rst_i && id_valid_i &&
             ((rs1_used_i && m_pending(rs1_addr_i)) ||
              (rs2_used_i && m_pending(rs2_addr_i)));
        exp_stall  = hz && !flush_i;
        exp_issue  = id_valid_i && !hz && !flush_i;
        exp_bubble = !exp_issue;
        exp_cnt    = m_stall_cnt;
        obs_stall  = stall_o;
        obs_issue  = issue_o;
        obs_bubble = bubble_o;
        obs_cnt    = stall_cnt_o;
        @(posedge clk);
        m_now++;
        if (rst_i) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_stall_cnt = '0;
        end else begin
            if (exp_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (exp_issue && rd_we_i && rd_addr_i != 0) begin
                m_busy[rd_addr_i]    = 1'b1;
                m_issue_t[rd_addr_i] = m_now;
`ifdef HAZARD_FWD_EN
                m_ld[rd_addr_i]      = is_load_i;
`endif
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] a1, input bit u1,
                         input logic [AW-1:0] a2, input bit u2,
                         input logic [AW-1:0] rd, input bit we, input bit ld,
                         input bit fl);
        id_valid_i = v;  rs1_addr_i = a1; rs1_used_i = u1;
        rs2_addr_i = a2; rs2_used_i = u2; rd_addr_i  = rd;
        rd_we_i    = we; is_load_i  = ld; flush_i    = fl;
    endtask

    // Idle long enough for every pending write to retire.
    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) tick();
    endtask

    // Hold the current decode instruction until it issues; count DUT stalls.
    task automatic wait_issue(output int stalls, output bit timed_out);
        stalls    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_issue === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (obs_stall === 1'b1) stalls++;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_i = 1'b1;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if ({obs_stall, obs_issue, obs_bubble} !== 3'b010)
                $display("FAIL reset_outputs cycle %0d: got s/i/b=%b%b%b want 010",
                         c, obs_stall, obs_issue, obs_bubble);
            else n_pass++;
        end
        n_total++;
        if (obs_cnt !== 32'd0)
            $display("FAIL reset_stall_cnt: got %0d want 0", obs_cnt);
        else n_pass++;
        rst_i = 1'b0;
    endtask

    task automatic test_raw();
        int stalls; bit to; logic [31:0] base;
        drain();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);      // addi x5
        tick();
        base = m_stall_cnt;
        drive(1, 5, 1, 0, 1, 6, 1, 0, 0);      // add x6,x5,x0
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != EXP_ALU_USE)
            $display("FAIL raw_stalls: got %0d (timeout=%0b) want %0d", stalls, to, EXP_ALU_USE);
        else n_pass++;
        n_total++;
        if (obs_cnt !== base + 32'(EXP_ALU_USE))
            $display("FAIL raw_stall_cnt: got %0d want %0d", obs_cnt, base + 32'(EXP_ALU_USE));
        else n_pass++;
    endtask

    task automatic test_x0();
        int stalls; bit to;
        drain();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);      // write to x0
        tick();
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0);      // reads x0 twice
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != 0)
            $display("FAIL x0_stalls: got %0d (timeout=%0b) want 0", stalls, to);
        else n_pass++;
    endtask

    task automatic test_flush();
        int stalls; bit to;
        drain();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);      // producer of x5 (load)
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 1);      // consumer, flushed
        tick();
        n_total++;
        if ({obs_stall, obs_issue, obs_bubble} !== 3'b001)
            $display("FAIL flush_outputs: got s/i/b=%b%b%b want 001",
                     obs_stall, obs_issue, obs_bubble);
        else n_pass++;
        // The scoreboard kept counting through the flush cycle.
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != EXP_LOAD_USE - 1)
            $display("FAIL flush_then_stalls: got %0d (timeout=%0b) want %0d",
                     stalls, to, EXP_LOAD_USE - 1);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        int stalls; bit to;
        drain();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        n_total++;
        if (obs_issue !== 1'b1)
            $display("FAIL overwrite_second_issue: got %b want 1", obs_issue);
        else n_pass++;
        drive(1, 1, 0, 7, 1, 9, 1, 0, 0);
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != EXP_ALU_USE)
            $display("FAIL overwrite_stalls: got %0d (timeout=%0b) want %0d", stalls, to, EXP_ALU_USE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        int stalls; bit to;
        drain();
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0);      // lw x8
        tick();
        drive(1, 8, 1, 8, 1, 9, 1, 0, 0);      // add x9,x8,x8
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != EXP_LOAD_USE)
            $display("FAIL load_use_stalls: got %0d (timeout=%0b) want %0d", stalls, to, EXP_LOAD_USE);
        else n_pass++;
        drain();
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0);      // addi x8
        tick();
        drive(1, 8, 1, 0, 1, 9, 1, 0, 0);      // add x9,x8,x0
        wait_issue(stalls, to);
        n_total++;
        if (to || stalls != EXP_ALU_USE)
            $display("FAIL alu_use_stalls: got %0d (timeout=%0b) want %0d", stalls, to, EXP_ALU_USE);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hazard();
        drain();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);      // lw x5
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        tick();
        n_total++;
        if (obs_stall !== 1'b1)
            $display("FAIL midrst_pre_stall: got %b want 1", obs_stall);
        else n_pass++;
        rst_i = 1'b1;
        tick();
        n_total++;
        if ({obs_stall, obs_issue, obs_bubble} !== 3'b010)
            $display("FAIL midrst_in_reset: got s/i/b=%b%b%b want 010",
                     obs_stall, obs_issue, obs_bubble);
        else n_pass++;
        rst_i = 1'b0;
        drive(1, 5, 1, 0, 0, 6, 0, 0, 0);
        tick();
        n_total++;
        if ({obs_stall, obs_issue, obs_cnt} !== {2'b01, 32'd0})
            $display("FAIL midrst_after: got s/i=%b%b cnt=%0d want 01 cnt=0",
                     obs_stall, obs_issue, obs_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        drain();
        for (int c = 0; c < 1500; c++) begin
            if (!hold) begin
                drive($urandom_range(0, 9) != 0,
                      AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, 1'b0);
            end
            flush_i = ($urandom_range(0, 15) == 0);
            rst_i   = ($urandom_range(0, 199) == 0);
            tick();
            hold = exp_stall;
            n_total++;
            if ({obs_stall, obs_issue, obs_bubble} !== {exp_stall, exp_issue, exp_bubble})
                $display("FAIL random_outputs cycle %0d: got s/i/b=%b%b%b want %b%b%b",
                         c, obs_stall, obs_issue, obs_bubble, exp_stall, exp_issue, exp_bubble);
            else n_pass++;
            n_total++;
            if (obs_cnt !== exp_cnt)
                $display("FAIL random_stall_cnt cycle %0d: got %0d want %0d", c, obs_cnt, exp_cnt);
            else n_pass++;
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw();
        test_x0();
        test_flush();
        test_overwrite();
        test_load_use();
        test_reset_mid_hazard();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
